// File: rtl/audio_mix_arbiter_if.sv
// ---------------------------------------------------------------------------
// audio_mix_arbiter_if
//
// Purpose: bundles the codec sample interface and the two sample-requester
// handshakes that the mixer arbiter sits between.
//
// Signals:
//   Init         codec init request (arbiter -> codec)
//   Init_Finish  codec init complete, level (codec -> arbiter)
//   data_over    codec busy shifting a sample; falling edge = new slot
//   LDATA/RDATA  16-bit signed left/right samples (arbiter -> codec)
//   bgm_valid    BGM sample available (BGM -> arbiter)
//   bgm_sample   16-bit signed BGM sample
//   bgm_ready    one-cycle pulse, BGM sample consumed (arbiter -> BGM)
//   sfx_valid    SFX sample available (SFX -> arbiter)
//   sfx_sample   16-bit signed SFX sample
//   sfx_ready    one-cycle pulse, SFX sample consumed (arbiter -> SFX)
//
// Modports:
//   master  the arbiter side
//   slave   the codec / requester side (environment)
// ---------------------------------------------------------------------------
interface audio_mix_arbiter_if;
    logic        Init;
    logic        Init_Finish;
    logic        data_over;
    logic [15:0] LDATA;
    logic [15:0] RDATA;
    logic        bgm_valid;
    logic [15:0] bgm_sample;
    logic        bgm_ready;
    logic        sfx_valid;
    logic [15:0] sfx_sample;
    logic        sfx_ready;

    modport master (
        output Init, LDATA, RDATA, bgm_ready, sfx_ready,
        input  Init_Finish, data_over, bgm_valid, bgm_sample,
               sfx_valid, sfx_sample
    );

    modport slave (
        input  Init, LDATA, RDATA, bgm_ready, sfx_ready,
        output Init_Finish, data_over, bgm_valid, bgm_sample,
               sfx_valid, sfx_sample
    );
endinterface

// File: rtl/audio_mix_arbiter.sv
// ---------------------------------------------------------------------------
// audio_mix_arbiter
//
// Purpose: sequences the codec sample interface and shares each codec sample
// slot between the background-music (BGM) and sound-effect (SFX) requesters.
// Per slot it fetches one sample from every valid requester, attenuates them,
// adds them with saturation and registers the result onto LDATA and RDATA.
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         asynchronous, active-low reset
//   bus           audio_mix_arbiter_if.master (codec + requester handshakes)
//   mute          forces the mixed result to 0; requesters still consumed
//   underrun_cnt  saturating count of slots with no valid source
//   overrun       sticky flag: slot tick arrived while FETCH or MIX was busy
//
// Parameters:
//   BGM_SHIFT   arithmetic right shift applied to BGM before mixing
//   SFX_SHIFT   arithmetic right shift applied to SFX before mixing
//   UNDERRUN_W  width of underrun_cnt
//
// Optional build macro AUDIO_MIX_DUCK_EN:
//   defined   -> BGM gets one extra bit of attenuation whenever SFX is
//                present, and an underrun slot decays the previous LDATA
//                by one bit instead of outputting silence.
//   undefined -> no ducking, underrun slots output 0.
// ---------------------------------------------------------------------------
module audio_mix_arbiter #(
    parameter int BGM_SHIFT  = 0,
    parameter int SFX_SHIFT  = 1,
    parameter int UNDERRUN_W = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    audio_mix_arbiter_if.master   bus,
    input  logic                  mute,
    output logic [UNDERRUN_W-1:0] underrun_cnt,
    output logic                  overrun
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_MIX   = 2'd3;

    logic [1:0]            state_q,        state_d;
    logic                  data_over_dly_q, data_over_dly_d;
    logic                  bgm_valid_q,    bgm_valid_d;
    logic [15:0]           bgm_sample_q,   bgm_sample_d;
    logic                  sfx_valid_q,    sfx_valid_d;
    logic [15:0]           sfx_sample_q,   sfx_sample_d;
    logic [15:0]           ldata_q,        ldata_d;
    logic [UNDERRUN_W-1:0] underrun_cnt_q, underrun_cnt_d;
    logic                  overrun_q,      overrun_d;

    logic                  slot_tick;
    logic                  link_lost;
    logic                  busy;
    logic                  underrun;
    logic signed [16:0]    bgm_ext;
    logic signed [16:0]    sfx_ext;
    logic signed [16:0]    bgm_scaled;
    logic signed [16:0]    sfx_scaled;
    logic signed [16:0]    mix_sum;
    logic [15:0]           mix_sat;
    logic [15:0]           mix_pre;
    logic [15:0]           mix_result;

    // A new codec slot begins on the falling edge of data_over.
    assign slot_tick = data_over_dly_q & ~bus.data_over;

    // Losing Init_Finish outside INIT means the codec needs re-initialising.
    assign link_lost = (state_q != ST_INIT) & ~bus.Init_Finish;
    assign busy      = (state_q == ST_FETCH) | (state_q == ST_MIX);
    assign underrun  = ~bgm_valid_q & ~sfx_valid_q;

    // Ready pulses are combinational in FETCH so they cover exactly that
    // cycle; gating with Init_Finish kills a pulse if the codec drops out.
    assign bus.bgm_ready = (state_q == ST_FETCH) & bus.Init_Finish & bus.bgm_valid;
    assign bus.sfx_ready = (state_q == ST_FETCH) & bus.Init_Finish & bus.sfx_valid;

    assign bus.Init      = (state_q == ST_INIT);
    assign bus.LDATA     = ldata_q;
    assign bus.RDATA     = ldata_q;
    assign underrun_cnt  = underrun_cnt_q;
    assign overrun       = overrun_q;

    // Mixing datapath: sign-extend to 17 bits so the sum of two full-scale
    // samples cannot wrap, then clamp back to 16 bits.
    always_comb begin
        bgm_ext    = $signed({bgm_sample_q[15], bgm_sample_q});
        sfx_ext    = $signed({sfx_sample_q[15], sfx_sample_q});
        bgm_scaled = '0;
        sfx_scaled = '0;
        if (bgm_valid_q) begin
`ifdef AUDIO_MIX_DUCK_EN
            if (sfx_valid_q)
                bgm_scaled = bgm_ext >>> (BGM_SHIFT + 1);
            else
                bgm_scaled = bgm_ext >>> BGM_SHIFT;
`else
            bgm_scaled = bgm_ext >>> BGM_SHIFT;
`endif
        end
        if (sfx_valid_q)
            sfx_scaled = sfx_ext >>> SFX_SHIFT;
        mix_sum = bgm_scaled + sfx_scaled;
        // Bits 16 and 15 disagree only when the sum left the 16-bit range.
        if (mix_sum[16] != mix_sum[15])
            mix_sat = mix_sum[16] ? 16'h8000 : 16'h7FFF;
        else
            mix_sat = mix_sum[15:0];
        if (underrun) begin
`ifdef AUDIO_MIX_DUCK_EN
            mix_pre = {ldata_q[15], ldata_q[15:1]};
`else
            mix_pre = 16'h0000;
`endif
        end else begin
            mix_pre = mix_sat;
        end
        mix_result = mute ? 16'h0000 : mix_pre;
    end

    // Slot sequencer: INIT -> IDLE -> FETCH -> MIX -> IDLE. Ticks that land
    // while FETCH or MIX is in progress are dropped and flagged as overrun.
    always_comb begin
        state_d         = state_q;
        data_over_dly_d = bus.data_over;
        bgm_valid_d     = bgm_valid_q;
        bgm_sample_d    = bgm_sample_q;
        sfx_valid_d     = sfx_valid_q;
        sfx_sample_d    = sfx_sample_q;
        ldata_d         = ldata_q;
        underrun_cnt_d  = underrun_cnt_q;
        overrun_d       = overrun_q | (slot_tick & busy);

        if (link_lost) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (bus.Init_Finish)
                        state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (slot_tick)
                        state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    bgm_valid_d  = bus.bgm_valid;
                    bgm_sample_d = bus.bgm_sample;
                    sfx_valid_d  = bus.sfx_valid;
                    sfx_sample_d = bus.sfx_sample;
                    state_d      = ST_MIX;
                end
                ST_MIX: begin
                    ldata_d = mix_result;
                    if (underrun && !(&underrun_cnt_q))
                        underrun_cnt_d = underrun_cnt_q + 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q         <= ST_INIT;
            data_over_dly_q <= 1'b0;
            bgm_valid_q     <= 1'b0;
            bgm_sample_q    <= 16'h0000;
            sfx_valid_q     <= 1'b0;
            sfx_sample_q    <= 16'h0000;
            ldata_q         <= 16'h0000;
            underrun_cnt_q  <= '0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            data_over_dly_q <= data_over_dly_d;
            bgm_valid_q     <= bgm_valid_d;
            bgm_sample_q    <= bgm_sample_d;
            sfx_valid_q     <= sfx_valid_d;
            sfx_sample_q    <= sfx_sample_d;
            ldata_q         <= ldata_d;
            underrun_cnt_q  <= underrun_cnt_d;
            overrun_q       <= overrun_d;
        end
    end

endmodule

// File: tb/tb_audio_mix_arbiter.sv
// ---------------------------------------------------------------------------
// tb_audio_mix_arbiter
//
// Directed testbench for audio_mix_arbiter with BGM_SHIFT=0, SFX_SHIFT=1.
// Inputs change 1 time unit after the falling clock edge; outputs are read
// on the falling edge. Expected values are hand-computed constants, with an
// alternate set for builds that define AUDIO_MIX_DUCK_EN.
// ---------------------------------------------------------------------------
module tb_audio_mix_arbiter;

    logic        Clk;
    logic        Reset;
    logic        mute;
    logic [15:0] underrun_cnt;
    logic        overrun;

    int checks;
    int failures;
    int bgm_pulses;
    int sfx_pulses;

    logic br_fetch, sr_fetch, br_mix, sr_mix;

`ifdef AUDIO_MIX_DUCK_EN
    localparam logic [15:0] EXP_SAT_POS = 16'h7000;
    localparam logic [15:0] EXP_SAT_NEG = 16'h9000;
    localparam logic [15:0] EXP_UR1     = 16'h0200;
    localparam logic [15:0] EXP_UR2     = 16'h0100;
    localparam logic [15:0] EXP_UR3     = 16'h0080;
    localparam logic [15:0] EXP_OVR_MIX = 16'h0180;
`else
    localparam logic [15:0] EXP_SAT_POS = 16'h7FFF;
    localparam logic [15:0] EXP_SAT_NEG = 16'h8000;
    localparam logic [15:0] EXP_UR1     = 16'h0000;
    localparam logic [15:0] EXP_UR2     = 16'h0000;
    localparam logic [15:0] EXP_UR3     = 16'h0000;
    localparam logic [15:0] EXP_OVR_MIX = 16'h0200;
`endif

    audio_mix_arbiter_if bus ();

    audio_mix_arbiter #(
        .BGM_SHIFT  (0),
        .SFX_SHIFT  (1),
        .UNDERRUN_W (16)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .bus          (bus),
        .mute         (mute),
        .underrun_cnt (underrun_cnt),
        .overrun      (overrun)
    );

    // Free-running 10-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Ready pulse counter, sampled on the falling edge.
    always @(negedge Clk) begin
        if (bus.bgm_ready === 1'b1) bgm_pulses++;
        if (bus.sfx_ready === 1'b1) sfx_pulses++;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Runs one codec slot: present samples, make data_over fall, and record
    // the ready outputs in the FETCH and MIX cycles. Returns on the falling
    // edge after LDATA/RDATA have been updated.
    task automatic apply_stimulus(input logic bv, input logic [15:0] bs,
                                  input logic sv, input logic [15:0] ss,
                                  output logic brf, output logic srf,
                                  output logic brm, output logic srm);
        @(negedge Clk); #1;
        bus.bgm_valid  = bv;
        bus.bgm_sample = bs;
        bus.sfx_valid  = sv;
        bus.sfx_sample = ss;
        bus.data_over  = 1'b1;
        @(negedge Clk); #1;
        bus.data_over  = 1'b0;
        @(negedge Clk);
        brf = bus.bgm_ready;
        srf = bus.sfx_ready;
        @(negedge Clk);
        brm = bus.bgm_ready;
        srm = bus.sfx_ready;
        @(negedge Clk);
        #1;
        bus.bgm_valid = 1'b0;
        bus.sfx_valid = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        bgm_pulses     = 0;
        sfx_pulses     = 0;
        Reset          = 1'b0;
        mute           = 1'b0;
        bus.Init_Finish = 1'b0;
        bus.data_over  = 1'b0;
        bus.bgm_valid  = 1'b0;
        bus.bgm_sample = 16'h0000;
        bus.sfx_valid  = 1'b0;
        bus.sfx_sample = 16'h0000;

        // Reset state and waiting for codec init.
        repeat (3) @(negedge Clk);
        check_output("rst_init",     bus.Init,     1);
        check_output("rst_ldata",    bus.LDATA,    0);
        check_output("rst_bgm_rdy",  bus.bgm_ready, 0);
        check_output("rst_underrun", underrun_cnt, 0);
        check_output("rst_overrun",  overrun,      0);
        #1 Reset = 1'b1;
        repeat (20) @(negedge Clk);
        check_output("wait_init",  bus.Init,  1);
        check_output("wait_rdata", bus.RDATA, 0);
        #1 bus.Init_Finish = 1'b1;
        @(negedge Clk);
        check_output("init_done", bus.Init, 0);

        // BGM only.
        bgm_pulses = 0;
        sfx_pulses = 0;
        apply_stimulus(1'b1, 16'h1000, 1'b0, 16'h0000, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("bgm_rdy_fetch", br_fetch, 1);
        check_output("bgm_rdy_mix",   br_mix,   0);
        check_output("sfx_rdy_fetch", sr_fetch, 0);
        check_output("bgm_ldata",     bus.LDATA, 16'h1000);
        check_output("bgm_rdata",     bus.RDATA, 16'h1000);
        check_output("bgm_pulses",    bgm_pulses, 1);
        check_output("sfx_pulses",    sfx_pulses, 0);

        // Positive and negative saturation with both sources.
        apply_stimulus(1'b1, 16'h7000, 1'b1, 16'h7000, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("both_bgm_rdy", br_fetch, 1);
        check_output("both_sfx_rdy", sr_fetch, 1);
        check_output("sat_pos",      bus.LDATA, EXP_SAT_POS);
        apply_stimulus(1'b1, 16'h9000, 1'b1, 16'h9000, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("sat_neg",      bus.RDATA, EXP_SAT_NEG);

        // Underrun slots after a known LDATA.
        apply_stimulus(1'b1, 16'h0400, 1'b0, 16'h0000, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("pre_underrun", bus.LDATA, 16'h0400);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("underrun1",     bus.LDATA, EXP_UR1);
        check_output("underrun1_rdy", br_fetch,  0);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("underrun2",     bus.LDATA, EXP_UR2);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("underrun3",     bus.LDATA, EXP_UR3);
        check_output("underrun_cnt",  underrun_cnt, 3);

        // Second data_over fall while the slot is still busy.
        @(negedge Clk); #1;
        bgm_pulses     = 0;
        sfx_pulses     = 0;
        bus.bgm_valid  = 1'b1;
        bus.bgm_sample = 16'h0100;
        bus.sfx_valid  = 1'b1;
        bus.sfx_sample = 16'h0200;
        bus.data_over  = 1'b1;
        @(negedge Clk); #1;
        bus.data_over  = 1'b0;
        @(negedge Clk); #1;
        bus.data_over  = 1'b1;
        @(negedge Clk); #1;
        bus.data_over  = 1'b0;
        repeat (6) @(negedge Clk);
        check_output("ovr_flag",       overrun,    1);
        check_output("ovr_bgm_pulses", bgm_pulses, 1);
        check_output("ovr_sfx_pulses", sfx_pulses, 1);
        check_output("ovr_ldata",      bus.LDATA,  EXP_OVR_MIX);
        #1;
        bus.bgm_valid = 1'b0;
        bus.sfx_valid = 1'b0;

        // Codec drops Init_Finish in the FETCH cycle.
        @(negedge Clk); #1;
        bus.bgm_valid  = 1'b1;
        bus.bgm_sample = 16'h5555;
        bus.sfx_valid  = 1'b1;
        bus.sfx_sample = 16'h5555;
        bus.data_over  = 1'b1;
        @(negedge Clk); #1;
        bus.data_over  = 1'b0;
        @(negedge Clk); #1;
        bus.Init_Finish = 1'b0;
        bgm_pulses      = 0;
        sfx_pulses      = 0;
        @(negedge Clk);
        check_output("drop_init",   bus.Init,  1);
        check_output("drop_ldata",  bus.LDATA, EXP_OVR_MIX);
        repeat (4) @(negedge Clk);
        check_output("drop_bgm_pulses", bgm_pulses, 0);
        check_output("drop_sfx_pulses", sfx_pulses, 0);
        check_output("drop_hold",   bus.RDATA, EXP_OVR_MIX);
        check_output("drop_overrun", overrun, 1);
        #1;
        bus.bgm_valid   = 1'b0;
        bus.sfx_valid   = 1'b0;
        bus.Init_Finish = 1'b1;
        @(negedge Clk);
        check_output("reinit_done", bus.Init, 0);
        apply_stimulus(1'b1, 16'h0300, 1'b0, 16'h0000, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("resume_rdy",   br_fetch,  1);
        check_output("resume_ldata", bus.LDATA, 16'h0300);

        // Mute: requesters consumed, output silent.
        mute = 1'b1;
        apply_stimulus(1'b1, 16'h1234, 1'b1, 16'h0100, br_fetch, sr_fetch, br_mix, sr_mix);
        check_output("mute_bgm_rdy", br_fetch,  1);
        check_output("mute_sfx_rdy", sr_fetch,  1);
        check_output("mute_ldata",   bus.LDATA, 0);
        check_output("mute_rdata",   bus.RDATA, 0);
        check_output("final_underrun_cnt", underrun_cnt, 3);
        mute = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
